// File: rtl/ps2_paddle_control.sv
// ps2_paddle_control: decodes PS/2 make/break scan codes (including the E0
// extended and F0 break prefixes) into press-and-hold key flags, and steps
// two saturating paddle positions once per movement tick.
module ps2_paddle_control #(
   parameter int SCREEN_H = 480,
   parameter int PADDLE_H = 64,
   parameter int STEP     = 4,
   parameter int TICK_DIV = 833333,
   parameter int YW       = 10
) (
   input  logic          inclock,
   input  logic          resetn,
   input  logic [7:0]    scan_code,
   input  logic          scan_valid,
   output logic [YW-1:0] p1_y,
   output logic [YW-1:0] p2_y,
   output logic [3:0]    keys_held,
   output logic          frame_tick
);

   localparam int              CW       = $clog2(TICK_DIV);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [YW:0]     Y_MAX    = (YW+1)'(SCREEN_H - PADDLE_H);
   localparam logic [YW:0]     STEP_X   = (YW+1)'(STEP);
   localparam logic [YW-1:0]   Y_INIT   = YW'((SCREEN_H - PADDLE_H) / 2);

   // Flag vector layout: {DN, UP, K, O, S, W}
   localparam int F_W  = 0;
   localparam int F_S  = 1;
   localparam int F_O  = 2;
   localparam int F_K  = 3;
   localparam int F_UP = 4;
   localparam int F_DN = 5;

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } dec_state_t;

   dec_state_t       state, state_next;
   logic [5:0]       flags, flags_next;
   logic [CW-1:0]    tick_cnt;

   // One-hot flag select for a scan code; zero for codes we do not track.
   // Arrow codes are recognised with or without the E0 prefix.
   function automatic logic [5:0] key_mask(input logic [7:0] code);
      logic [5:0] m;
      m = '0;
      case (code)
         8'h1D:   m[F_W]  = 1'b1;
         8'h1B:   m[F_S]  = 1'b1;
         8'h44:   m[F_O]  = 1'b1;
         8'h42:   m[F_K]  = 1'b1;
         8'h75:   m[F_UP] = 1'b1;
         8'h72:   m[F_DN] = 1'b1;
         default: m = '0;
      endcase
      return m;
   endfunction

   // Step a paddle one tick; computed one bit wider so underflow shows up in
   // the top bit and overflow can be compared against the bottom bound.
   function automatic logic [YW-1:0] move_y(input logic [YW-1:0] y,
                                            input logic up,
                                            input logic dn);
      logic [YW:0] ext;
      logic [YW:0] res;
      ext = {1'b0, y};
      res = ext;
      if (up && !dn) begin
         res = ext - STEP_X;
         if (res[YW]) res = '0;
      end else if (dn && !up) begin
         res = ext + STEP_X;
         if (res > Y_MAX) res = Y_MAX;
      end
      return res[YW-1:0];
   endfunction

   // Decoder state and key flags; only this register sees scan_valid.
   always_ff @(posedge inclock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         flags <= '0;
      end else begin
         state <= state_next;
         flags <= flags_next;
      end
   end

   // Prefix tracking: E0 only marks "extended", F0 marks "break"; the final
   // mapped byte sets or clears its flag. AA/FA fall into "other" and reset to IDLE.
   always_comb begin
      state_next = state;
      flags_next = flags;
      if (scan_valid) begin
         unique case (state)
            IDLE: begin
               if (scan_code == 8'hE0)      state_next = EXT;
               else if (scan_code == 8'hF0) state_next = BRK;
               else                         flags_next = flags | key_mask(scan_code);
            end
            EXT: begin
               if (scan_code == 8'hF0)      state_next = EXT_BRK;
               else if (scan_code == 8'hE0) state_next = EXT;
               else begin
                  flags_next = flags | key_mask(scan_code);
                  state_next = IDLE;
               end
            end
            BRK: begin
               if (scan_code == 8'hF0)      state_next = BRK;
               else if (scan_code == 8'hE0) state_next = EXT_BRK;
               else begin
                  flags_next = flags & ~key_mask(scan_code);
                  state_next = IDLE;
               end
            end
            EXT_BRK: begin
               if (scan_code == 8'hF0 || scan_code == 8'hE0) state_next = EXT_BRK;
               else begin
                  flags_next = flags & ~key_mask(scan_code);
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Player-facing key view, one cycle behind the flags; the letter key and
   // arrow key for player 2 share a direction, so either one holds it.
   always_ff @(posedge inclock or negedge resetn) begin
      if (!resetn) begin
         keys_held <= '0;
      end else begin
         keys_held <= {flags[F_K] | flags[F_DN],
                       flags[F_O] | flags[F_UP],
                       flags[F_S],
                       flags[F_W]};
      end
   end

   // Movement tick: positions step on the last count using the flags already
   // registered, so a byte arriving on that same cycle waits for the next tick.
   always_ff @(posedge inclock or negedge resetn) begin
      if (!resetn) begin
         tick_cnt   <= '0;
         frame_tick <= 1'b0;
         p1_y       <= Y_INIT;
         p2_y       <= Y_INIT;
      end else if (tick_cnt == CNT_LAST) begin
         tick_cnt   <= '0;
         frame_tick <= 1'b1;
         p1_y       <= move_y(p1_y, flags[F_W], flags[F_S]);
         p2_y       <= move_y(p2_y, flags[F_O] | flags[F_UP], flags[F_K] | flags[F_DN]);
      end else begin
         tick_cnt   <= tick_cnt + 1'b1;
         frame_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_paddle_control.sv
// tb_ps2_paddle_control: directed press/hold/release scenarios followed by a
// randomized byte stream, all checked every cycle against a behavioural model
// that tracks held keys as booleans and positions as plain integers.
module tb_ps2_paddle_control;

   localparam int SCREEN_H = 480;
   localparam int PADDLE_H = 64;
   localparam int STEP     = 4;
   localparam int TICK_DIV = 4;
   localparam int YW       = 10;
   localparam int Y_MAX    = SCREEN_H - PADDLE_H;

   logic          inclock    = 1'b0;
   logic          resetn     = 1'b0;
   logic [7:0]    scan_code  = 8'h00;
   logic          scan_valid = 1'b0;
   logic [YW-1:0] p1_y;
   logic [YW-1:0] p2_y;
   logic [3:0]    keys_held;
   logic          frame_tick;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   bit         m_w, m_s, m_o, m_k, m_up, m_dn;
   bit         m_brk;
   int         m_p1, m_p2, m_cnt;
   logic [3:0] m_keys;
   bit         m_tick;
   int         saved;

   logic [7:0] pool [10] = '{8'h1D, 8'h1B, 8'h44, 8'h42, 8'h75,
                             8'h72, 8'hE0, 8'hF0, 8'hAA, 8'hFA};

   ps2_paddle_control #(
      .SCREEN_H (SCREEN_H),
      .PADDLE_H (PADDLE_H),
      .STEP     (STEP),
      .TICK_DIV (TICK_DIV),
      .YW       (YW)
   ) dut (
      .inclock    (inclock),
      .resetn     (resetn),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .p1_y       (p1_y),
      .p2_y       (p2_y),
      .keys_held  (keys_held),
      .frame_tick (frame_tick)
   );

   // 100 MHz simulation clock
   always #5 inclock = ~inclock;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string phase);
      checkOutput({phase, " p1_y"},       32'(p1_y),       32'(m_p1));
      checkOutput({phase, " p2_y"},       32'(p2_y),       32'(m_p2));
      checkOutput({phase, " keys_held"},  32'(keys_held),  32'(m_keys));
      checkOutput({phase, " frame_tick"}, 32'(frame_tick), 32'(m_tick));
   endtask

   function automatic void modelReset();
      {m_w, m_s, m_o, m_k, m_up, m_dn} = '0;
      m_brk  = 1'b0;
      m_p1   = Y_MAX / 2;
      m_p2   = Y_MAX / 2;
      m_cnt  = 0;
      m_keys = '0;
      m_tick = 1'b0;
   endfunction

   // A pending F0 turns the next tracked key into a release; E0 only says
   // "extended" and never changes the meaning of the final byte.
   function automatic void modelByte(input logic [7:0] code);
      case (code)
         8'hE0: ;
         8'hF0: m_brk = 1'b1;
         8'h1D: begin m_w  = !m_brk; m_brk = 1'b0; end
         8'h1B: begin m_s  = !m_brk; m_brk = 1'b0; end
         8'h44: begin m_o  = !m_brk; m_brk = 1'b0; end
         8'h42: begin m_k  = !m_brk; m_brk = 1'b0; end
         8'h75: begin m_up = !m_brk; m_brk = 1'b0; end
         8'h72: begin m_dn = !m_brk; m_brk = 1'b0; end
         default: m_brk = 1'b0;
      endcase
   endfunction

   function automatic int moveY(input int y, input bit up, input bit dn);
      if (up && !dn) return (y - STEP < 0) ? 0 : y - STEP;
      if (dn && !up) return (y + STEP > Y_MAX) ? Y_MAX : y + STEP;
      return y;
   endfunction

   // One clock of the model: outputs come from the key state held before the
   // edge, then the byte (if any) updates that key state.
   function automatic void modelCycle(input logic [7:0] code, input bit valid);
      m_keys = {m_k | m_dn, m_o | m_up, m_s, m_w};
      if (m_cnt == TICK_DIV - 1) begin
         m_p1   = moveY(m_p1, m_w, m_s);
         m_p2   = moveY(m_p2, m_o | m_up, m_k | m_dn);
         m_tick = 1'b1;
         m_cnt  = 0;
      end else begin
         m_tick = 1'b0;
         m_cnt++;
      end
      if (valid) modelByte(code);
   endfunction

   task automatic applyStimulus(input logic [7:0] code, input bit valid);
      scan_code  = code;
      scan_valid = valid;
      @(posedge inclock);
      #1;
      modelCycle(code, valid);
      scan_valid = 1'b0;
      scan_code  = 8'h00;
      checkAll("cycle");
   endtask

   task automatic sendByte(input logic [7:0] code);
      applyStimulus(code, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(8'h00, 1'b0);
   endtask

   task automatic applyReset();
      resetn = 1'b0;
      modelReset();
      @(posedge inclock);
      #1;
      checkAll("reset");
      resetn = 1'b1;
   endtask

   initial begin
      $display("[TB] start");

      // Reset values and tick cadence
      applyReset();
      checkOutput("reset p1_y", 32'(p1_y), 32'd208);
      checkOutput("reset p2_y", 32'(p2_y), 32'd208);
      checkOutput("reset keys", 32'(keys_held), 32'd0);
      idle(3);
      checkOutput("no tick before cycle 4", 32'(frame_tick), 32'd0);
      idle(1);
      checkOutput("first tick cycle 4", 32'(frame_tick), 32'd1);
      idle(3);
      checkOutput("no tick mid period", 32'(frame_tick), 32'd0);
      idle(1);
      checkOutput("second tick cycle 8", 32'(frame_tick), 32'd1);

      // W held: p1 climbs to the top and stays there
      sendByte(8'h1D);
      idle(1);
      checkOutput("W held", 32'(keys_held), 32'b0001);
      idle(240);
      checkOutput("p1 saturates at 0", 32'(p1_y), 32'd0);
      sendByte(8'hF0);
      sendByte(8'h1D);
      idle(2);
      checkOutput("W released", 32'(keys_held), 32'd0);
      idle(8);
      checkOutput("p1 frozen", 32'(p1_y), 32'd0);

      // Extended DN held: p2 descends to the bottom bound
      sendByte(8'hE0);
      sendByte(8'h72);
      idle(2);
      checkOutput("DN held", 32'(keys_held), 32'b1000);
      idle(240);
      checkOutput("p2 saturates at 416", 32'(p2_y), 32'd416);
      sendByte(8'hE0);
      sendByte(8'hF0);
      sendByte(8'h72);
      idle(2);
      checkOutput("DN released", 32'(keys_held), 32'd0);

      // O and UP overlap: p2_up holds until both are released
      sendByte(8'h44);
      sendByte(8'hE0);
      sendByte(8'h75);
      sendByte(8'hF0);
      sendByte(8'h44);
      idle(2);
      checkOutput("UP still held after O break", 32'(keys_held), 32'b0100);
      sendByte(8'hE0);
      sendByte(8'hF0);
      sendByte(8'h75);
      idle(2);
      checkOutput("UP released", 32'(keys_held), 32'd0);

      // W and S together cancel; releasing S lets W move p1 up
      sendByte(8'h1B);
      idle(40);
      sendByte(8'h1D);
      idle(2);
      checkOutput("W and S held", 32'(keys_held), 32'b0011);
      saved = m_p1;
      idle(12);
      checkOutput("p1 frozen with both held", 32'(p1_y), 32'(saved));
      while (m_cnt != 0) idle(1);
      sendByte(8'hF0);
      sendByte(8'h1B);
      idle(2);
      checkOutput("tick after S release", 32'(frame_tick), 32'd1);
      checkOutput("p1 steps up after S release", 32'(p1_y), 32'(saved - STEP));

      // Reset in the middle of an E0 F0 sequence, then a fresh make
      sendByte(8'hE0);
      sendByte(8'hF0);
      applyReset();
      sendByte(8'h1D);
      idle(1);
      checkOutput("make after mid-seq reset", 32'(keys_held), 32'b0001);
      sendByte(8'hF0);
      sendByte(8'h1D);
      idle(2);

      // A make arriving on the tick cycle only acts on the following tick
      while (m_cnt != TICK_DIV - 1) idle(1);
      saved = m_p1;
      sendByte(8'h1D);
      checkOutput("tick on make cycle", 32'(frame_tick), 32'd1);
      checkOutput("no move on make cycle", 32'(p1_y), 32'(saved));
      idle(4);
      checkOutput("move on following tick", 32'(p1_y), 32'(saved - STEP));

      // Random byte stream with gaps and occasional resets
      for (int i = 0; i < 800; i++) begin
         int sel;
         logic [7:0] code;
         sel = $urandom_range(0, 10);
         code = (sel == 10) ? 8'($urandom_range(0, 255)) : pool[sel];
         if ($urandom_range(0, 199) == 0)  applyReset();
         else if ($urandom_range(0, 1) == 1) sendByte(code);
         else                              idle(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
